// File: rtl/nibble_pair_demux_if.sv
// nibble_pair_demux_if
//   Bus bundle for the nibble pair demultiplexer.
//   master: the upstream mux stage plus the consumer. It drives D/S/G_N,
//           ACK and ERR_CLR, and it observes the outputs.
//   slave : the demux block. It samples the inputs and drives QA/QB,
//           PAIR_VLD, BUSY, ERR and OVF.
interface nibble_pair_demux_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             S;
  logic             G_N;
  logic             ACK;
  logic             ERR_CLR;
  logic [WIDTH-1:0] QA;
  logic [WIDTH-1:0] QB;
  logic             PAIR_VLD;
  logic             BUSY;
  logic             ERR;
  logic             OVF;

  modport master (
    output D, S, G_N, ACK, ERR_CLR,
    input  QA, QB, PAIR_VLD, BUSY, ERR, OVF
  );

  modport slave (
    input  D, S, G_N, ACK, ERR_CLR,
    output QA, QB, PAIR_VLD, BUSY, ERR, OVF
  );
endinterface

// File: rtl/nibble_pair_demux.sv
// nibble_pair_demux
//   Receive end of a time-multiplexed A/B nibble bus. It captures the A
//   nibble into a shadow register. When the matching B nibble arrives, it
//   presents the pair on QA/QB and holds PAIR_VLD until ACK.
//   Ports:
//     CLK   - rising-edge clock
//     CLR_N - asynchronous active-low reset
//     bus   - slave modport:
//             inputs  D, S (0=A, 1=B), G_N (strobe, active low), ACK, ERR_CLR
//             outputs QA, QB, PAIR_VLD, BUSY (in GOT_A),
//                     ERR (ordering error), OVF (strobe while a pair is pending)
module nibble_pair_demux #(
  parameter int WIDTH      = 4,
  parameter bit STICKY_ERR = 1'b1
) (
  input  logic                  CLK,
  input  logic                  CLR_N,
  nibble_pair_demux_if.slave    bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GOT_A = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shadow_a;
  logic [WIDTH-1:0] r_qa;
  logic [WIDTH-1:0] r_qb;
  logic             r_vld;
  logic             r_busy;
  logic             r_err;
  logic             r_ovf;

  logic       w_strobe;
  logic [1:0] w_nxt_state;
  logic       w_cap_a;
  logic       w_cap_pair;
  logic       w_clr_vld;
  logic       w_err_set;
  logic       w_ovf_set;

  assign w_strobe = ~bus.G_N;

  always_comb begin
    w_nxt_state = r_state;
    w_cap_a     = 1'b0;
    w_cap_pair  = 1'b0;
    w_clr_vld   = 1'b0;
    w_err_set   = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_strobe) begin
          if (!bus.S) begin
            w_cap_a     = 1'b1;
            w_nxt_state = ST_GOT_A;
          end else begin
            w_err_set   = 1'b1;
          end
        end
      end
      ST_GOT_A: begin
        if (w_strobe) begin
          if (bus.S) begin
            w_cap_pair  = 1'b1;
            w_nxt_state = ST_FULL;
          end else begin
            // A repeated: keep the newest A and flag the ordering error
            w_cap_a     = 1'b1;
            w_err_set   = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (bus.ACK) begin
          // On an acknowledge edge the block behaves as IDLE. A strobe on
          // the same edge starts the next pair, so there is no bubble.
          w_clr_vld   = 1'b1;
          w_nxt_state = ST_IDLE;
          if (w_strobe) begin
            if (!bus.S) begin
              w_cap_a     = 1'b1;
              w_nxt_state = ST_GOT_A;
            end else begin
              w_err_set   = 1'b1;
            end
          end
        end else if (w_strobe) begin
          w_ovf_set = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state    <= ST_IDLE;
      r_shadow_a <= '0;
      r_qa       <= '0;
      r_qb       <= '0;
      r_vld      <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_busy  <= (w_nxt_state == ST_GOT_A);
      if (w_cap_a)    r_shadow_a <= bus.D;
      if (w_cap_pair) begin
        r_qa  <= r_shadow_a;
        r_qb  <= bus.D;
        r_vld <= 1'b1;
      end else if (w_clr_vld) begin
        r_vld <= 1'b0;
      end
      // In sticky mode a new set condition overrides a clear on the same edge.
      if (STICKY_ERR) begin
        r_err <= w_err_set | (r_err & ~bus.ERR_CLR);
        r_ovf <= w_ovf_set | (r_ovf & ~bus.ERR_CLR);
      end else begin
        r_err <= w_err_set;
        r_ovf <= w_ovf_set;
      end
    end
  end

  assign bus.QA       = r_qa;
  assign bus.QB       = r_qb;
  assign bus.PAIR_VLD = r_vld;
  assign bus.BUSY     = r_busy;
  assign bus.ERR      = r_err;
  assign bus.OVF      = r_ovf;

endmodule

// File: tb/tb_nibble_pair_demux.sv
// Testbench for nibble_pair_demux. Two instances share the same stimulus:
// u0 in sticky-flag mode and u1 in pulse-flag mode. Expected pairs go into a
// queue as stimulus is issued. A monitor pops one entry on each rising
// PAIR_VLD of u0.
module tb_nibble_pair_demux;
  logic       CLK = 1'b0;
  logic       CLR_N;
  logic [3:0] d;
  logic       s, g_n, ack, eclr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  nibble_pair_demux_if #(.WIDTH(4)) bus0 ();
  nibble_pair_demux_if #(.WIDTH(4)) bus1 ();

  assign bus0.D = d;  assign bus0.S = s;  assign bus0.G_N = g_n;
  assign bus0.ACK = ack;  assign bus0.ERR_CLR = eclr;
  assign bus1.D = d;  assign bus1.S = s;  assign bus1.G_N = g_n;
  assign bus1.ACK = ack;  assign bus1.ERR_CLR = eclr;

  nibble_pair_demux #(.WIDTH(4), .STICKY_ERR(1'b1)) u0 (.CLK(CLK), .CLR_N(CLR_N), .bus(bus0));
  nibble_pair_demux #(.WIDTH(4), .STICKY_ERR(1'b0)) u1 (.CLK(CLK), .CLR_N(CLR_N), .bus(bus1));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply the inputs for the next rising edge, then return 1ns after it.
  task automatic cyc(input logic gn, input logic sv, input logic [3:0] dv,
                     input logic ak, input logic ec);
    g_n = gn; s = sv; d = dv; ack = ak; eclr = ec;
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_qa"},  {28'd0, bus0.QA}, 32'h0);
    chk({nm, "_qb"},  {28'd0, bus0.QB}, 32'h0);
    chk({nm, "_vld"}, {31'd0, bus0.PAIR_VLD}, 32'h0);
    chk({nm, "_busy"},{31'd0, bus0.BUSY}, 32'h0);
    chk({nm, "_err"}, {31'd0, bus0.ERR | bus1.ERR}, 32'h0);
    chk({nm, "_ovf"}, {31'd0, bus0.OVF | bus1.OVF}, 32'h0);
  endtask

  // Scoreboard monitor: a rising PAIR_VLD means a new pair is presented.
  logic prev_vld = 1'b0;
  always @(negedge CLK) begin
    if (bus0.PAIR_VLD && !prev_vld) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pair_unexpected: got %0h%0h expected none", bus0.QA, bus0.QB);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({bus0.QA, bus0.QB} !== e) begin
          n_fail++;
          $display("FAIL pair: got %0h expected %0h", {bus0.QA, bus0.QB}, e);
        end
      end
    end
    prev_vld <= bus0.PAIR_VLD;
  end

  initial begin
    CLR_N = 1'b0; g_n = 1'b1; s = 1'b0; d = 4'h0; ack = 1'b0; eclr = 1'b0;
    idle(); idle();
    CLR_N = 1'b1;
    idle();
    chk_zero("reset");

    // Basic pair with ACK held low for 3 cycles
    exp_q.push_back(8'hA5);
    cyc(1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
    chk("basic_busy", {31'd0, bus0.BUSY}, 32'h1);
    chk("basic_vld0", {31'd0, bus0.PAIR_VLD}, 32'h0);
    cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    chk("basic_vld1", {31'd0, bus0.PAIR_VLD}, 32'h1);
    chk("basic_busy0", {31'd0, bus0.BUSY}, 32'h0);
    repeat (3) begin
      idle();
      chk("basic_hold", {31'd0, bus0.PAIR_VLD}, 32'h1);
    end
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("basic_ackvld", {31'd0, bus0.PAIR_VLD}, 32'h0);
    chk("basic_ackq", {24'd0, bus0.QA, bus0.QB}, 32'hA5);

    // Overrun while FULL with (A,5)
    exp_q.push_back(8'hA5);
    cyc(1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'h9, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, bus0.OVF}, 32'h1);
    chk("ovf_set_p", {31'd0, bus1.OVF}, 32'h1);
    chk("ovf_q", {24'd0, bus0.QA, bus0.QB}, 32'hA5);
    chk("ovf_full", {31'd0, bus0.PAIR_VLD}, 32'h1);
    chk("ovf_noerr", {31'd0, bus0.ERR}, 32'h0);
    cyc(1'b0, 1'b0, 4'h9, 1'b0, 1'b1);
    chk("ovf_setwins", {31'd0, bus0.OVF}, 32'h1);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("ovf_clr", {31'd0, bus0.OVF}, 32'h0);
    chk("ovf_pulse_end", {31'd0, bus1.OVF}, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);

    // Back-to-back: ACK together with the next A strobe
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h78);
    cyc(1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
    chk("b2b_q1", {24'd0, bus0.QA, bus0.QB}, 32'h3C);
    cyc(1'b0, 1'b0, 4'h7, 1'b1, 1'b0);
    chk("b2b_bubble", {31'd0, bus0.PAIR_VLD}, 32'h0);
    chk("b2b_busy", {31'd0, bus0.BUSY}, 32'h1);
    cyc(1'b0, 1'b1, 4'h8, 1'b0, 1'b0);
    chk("b2b_vld", {31'd0, bus0.PAIR_VLD}, 32'h1);
    chk("b2b_flags", {30'd0, bus0.ERR, bus0.OVF}, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);

    // Ordering errors
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    chk("ord_err", {31'd0, bus0.ERR}, 32'h1);
    chk("ord_err_p", {31'd0, bus1.ERR}, 32'h1);
    chk("ord_qb", {28'd0, bus0.QB}, 32'h8);
    chk("ord_idle", {30'd0, bus0.BUSY, bus0.PAIR_VLD}, 32'h0);
    idle();
    chk("ord_sticky", {31'd0, bus0.ERR}, 32'h1);
    chk("ord_pulse_1cyc", {31'd0, bus1.ERR}, 32'h0);
    exp_q.push_back(8'h23);
    cyc(1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'h2, 1'b0, 1'b0);
    chk("rep_a_busy", {31'd0, bus0.BUSY}, 32'h1);
    chk("rep_a_err_p", {31'd0, bus1.ERR}, 32'h1);
    cyc(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
    chk("rep_q", {24'd0, bus0.QA, bus0.QB}, 32'h23);
    chk("rep_err_hold", {31'd0, bus0.ERR}, 32'h1);
    chk("rep_err_p0", {31'd0, bus1.ERR}, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("err_clr", {31'd0, bus0.ERR}, 32'h0);

    // Reset mid-pair, asserted between clock edges
    cyc(1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
    chk("mid_busy", {31'd0, bus0.BUSY}, 32'h1);
    g_n = 1'b1;
    #2 CLR_N = 1'b0;
    #1 chk_zero("async_rst");
    #2 CLR_N = 1'b1;
    repeat (5) idle();
    chk_zero("post_rst");
    cyc(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
    chk("lone_b_err", {31'd0, bus0.ERR}, 32'h1);
    chk("lone_b_err_p", {31'd0, bus1.ERR}, 32'h1);
    chk("lone_b_nopair", {31'd0, bus0.PAIR_VLD}, 32'h0);
    idle();
    chk("lone_b_pulse_end", {31'd0, bus1.ERR}, 32'h0);
    idle();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
